hazard_scoreboard: RTL and testbench

- Parametrised successor to the pipeline forwarding logic.
- Adds a per-register latency scoreboard, so that multi-cycle scalar and vector ops (loads, interpolation MACs) stall the decode stage cycle-accurately.
- Also keeps EX-stage operand forwarding from the MEM and WB result buses.
- Sits between decode (issue handshake) and EX (forward selects and forwarded data).

---
 rtl/hazard_scoreboard.sv | 190 +++++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-stage RAW/WAW stall via per-register latency
// counters, plus EX-stage operand forwarding from the MEM/WB result buses.
// Optional hazard statistics counters are built when HAZARD_STATS_EN is defined.

// Per-register countdown: cycles left until the producer's result is on result_mem.
module hs_cnt_cell #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] lat,
  output logic [CW-1:0] cnt
);
  // A new producer's latency overrides the running decrement.
  always_ff @(posedge clk) begin
    if (rst)             cnt <= '0;
    else if (load)       cnt <= lat;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end
endmodule

// Per-operand forward select: MEM beats WB, register 0 never forwards.
module hs_fwd_mux #(
  parameter int AW      = 5,
  parameter int VDATA_W = 256
) (
  input  logic               rst,
  input  logic [AW-1:0]      src,
  input  logic [AW-1:0]      rd_mem,
  input  logic [AW-1:0]      rd_wb,
  input  logic               we_mem,
  input  logic               we_wb,
  input  logic [VDATA_W-1:0] result_mem,
  input  logic [VDATA_W-1:0] result_wb,
  output logic [1:0]         sel,
  output logic [VDATA_W-1:0] data
);
  // Regfile path returns zero data; outputs held at zero during reset.
  always_comb begin
    sel  = 2'd0;
    data = '0;
    if (!rst && src != '0) begin
      if (we_mem && rd_mem == src) begin
        sel  = 2'd1;
        data = result_mem;
      end else if (we_wb && rd_wb == src) begin
        sel  = 2'd2;
        data = result_wb;
      end
    end
  end
endmodule

module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int SDATA_W  = 32,
  parameter int VDATA_W  = 256,
  parameter int MAX_LAT  = 8,
  parameter int AW       = $clog2(NUM_REGS),
  parameter int CW       = $clog2(MAX_LAT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  output logic               id_ready,
  input  logic [AW-1:0]      id_rs1,
  input  logic [AW-1:0]      id_rs2,
  input  logic               id_use_rs1,
  input  logic               id_use_rs2,
  input  logic [AW-1:0]      id_rd,
  input  logic               id_we,
  input  logic [CW-1:0]      id_lat,
  input  logic [AW-1:0]      rd_mem,
  input  logic [AW-1:0]      rd_wb,
  input  logic               write_enable_mem,
  input  logic               write_enable_wb,
  input  logic [VDATA_W-1:0] result_mem,
  input  logic [VDATA_W-1:0] result_wb,
  output logic [1:0]         fwd_a_sel,
  output logic [1:0]         fwd_b_sel,
  output logic [SDATA_W-1:0] resultA,
  output logic [SDATA_W-1:0] resultB,
  output logic [VDATA_W-1:0] vresultA,
`ifdef HAZARD_STATS_EN
  output logic [31:0]        stall_cycles,
  output logic [31:0]        raw_stalls,
  output logic [31:0]        waw_stalls,
  output logic [31:0]        fwd_count,
`endif
  output logic [VDATA_W-1:0] vresultB
);
  localparam logic [CW-1:0] LAT_MAX = CW'(MAX_LAT);

  logic [NUM_REGS-1:0][CW-1:0] cnt;
  logic [1:0][AW-1:0]          ex_src;
  logic [1:0][1:0]             sel;
  logic [1:0][VDATA_W-1:0]     data;
  logic [CW-1:0]               lat_c;
  logic                        raw, waw, issue;

  // Out-of-range latencies are clamped rather than rejected.
  always_comb begin
    lat_c = id_lat;
    if (id_lat == '0)        lat_c = CW'(1);
    else if (id_lat > LAT_MAX) lat_c = LAT_MAX;
  end

  // cnt == 1 means the result arrives on result_mem just as the consumer hits EX.
  assign raw = (id_use_rs1 && id_rs1 != '0 && cnt[id_rs1] > CW'(1)) ||
               (id_use_rs2 && id_rs2 != '0 && cnt[id_rs2] > CW'(1));
  // A shorter younger write must not land before an older longer one.
  assign waw = id_we && id_rd != '0 && cnt[id_rd] > lat_c;

  assign id_ready = !rst && !raw && !waw;
  assign issue    = id_valid && id_ready;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    if (r == 0) begin : g_zero
      assign cnt[r] = '0;
    end else begin : g_cell
      hs_cnt_cell #(.CW(CW)) u_cell (
        .clk  (clk),
        .rst  (rst),
        .load (issue && id_we && id_rd == AW'(r)),
        .lat  (lat_c),
        .cnt  (cnt[r])
      );
    end
  end

  // EX source latch: unused sources and bubbles carry register 0 (never forwards).
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_src <= '0;
    end else if (issue) begin
      ex_src[0] <= id_use_rs1 ? id_rs1 : '0;
      ex_src[1] <= id_use_rs2 ? id_rs2 : '0;
    end else begin
      ex_src <= '0;
    end
  end

  for (genvar o = 0; o < 2; o++) begin : g_op
    hs_fwd_mux #(.AW(AW), .VDATA_W(VDATA_W)) u_fwd (
      .rst        (rst),
      .src        (ex_src[o]),
      .rd_mem     (rd_mem),
      .rd_wb      (rd_wb),
      .we_mem     (write_enable_mem),
      .we_wb      (write_enable_wb),
      .result_mem (result_mem),
      .result_wb  (result_wb),
      .sel        (sel[o]),
      .data       (data[o])
    );
  end

  assign fwd_a_sel = sel[0];
  assign fwd_b_sel = sel[1];
  assign vresultA  = data[0];
  assign vresultB  = data[1];
  assign resultA   = data[0][SDATA_W-1:0];
  assign resultB   = data[1][SDATA_W-1:0];

`ifdef HAZARD_STATS_EN
  logic        stall;
  logic [1:0]  nfwd;
  logic [32:0] fwd_sum;

  assign stall   = id_valid && !id_ready;
  assign nfwd    = {1'b0, sel[0] != 2'd0} + {1'b0, sel[1] != 2'd0};
  assign fwd_sum = {1'b0, fwd_count} + {31'b0, nfwd};

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      raw_stalls   <= '0;
      waw_stalls   <= '0;
      fwd_count    <= '0;
    end else begin
      if (stall && stall_cycles != '1)       stall_cycles <= stall_cycles + 1'b1;
      if (stall && raw && raw_stalls != '1)  raw_stalls   <= raw_stalls + 1'b1;
      if (stall && waw && waw_stalls != '1)  waw_stalls   <= waw_stalls + 1'b1;
      fwd_count <= fwd_sum[32] ? '1 : fwd_sum[31:0];
    end
  end
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: the driver pushes expected values per
// cycle into a queue; a negedge monitor pops and compares them.
module tb_hazard_scoreboard;
  localparam int AW = 5, CW = 4, SW = 32, VW = 256;
  localparam int S_RDY = 0, S_ASEL = 1, S_BSEL = 2, S_RA = 3, S_RB = 4,
                 S_VA = 5, S_VB = 6, S_STALL = 7, S_RAW = 8, S_WAW = 9, S_FWD = 10;
  localparam logic [VW-1:0] PAT_M = {64'hA5A5_0000_1111_2222, 64'h3333_4444_5555_6666,
                                     64'h7777_8888_9999_AAAA, 64'hBBBB_CCCC_DEAD_BEEF};
  localparam logic [VW-1:0] PAT_W = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                     64'h0F0F_F0F0_0F0F_F0F0, 64'hCAFE_F00D_1357_9BDF};

  logic clk = 0, rst;
  logic id_valid, id_ready, id_use_rs1, id_use_rs2, id_we;
  logic [AW-1:0] id_rs1, id_rs2, id_rd, rd_mem, rd_wb;
  logic [CW-1:0] id_lat;
  logic write_enable_mem, write_enable_wb;
  logic [VW-1:0] result_mem, result_wb, vresultA, vresultB;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [SW-1:0] resultA, resultB;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles, raw_stalls, waw_stalls, fwd_count;
`endif

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_we(id_we), .id_lat(id_lat), .rd_mem(rd_mem), .rd_wb(rd_wb),
    .write_enable_mem(write_enable_mem), .write_enable_wb(write_enable_wb),
    .result_mem(result_mem), .result_wb(result_wb),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .resultA(resultA), .resultB(resultB),
    .vresultA(vresultA),
`ifdef HAZARD_STATS_EN
    .stall_cycles(stall_cycles), .raw_stalls(raw_stalls), .waw_stalls(waw_stalls),
    .fwd_count(fwd_count),
`endif
    .vresultB(vresultB)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    int            sig;
    logic [VW-1:0] exp;
    string         name;
  } item_t;

  item_t q[$];
  int cyc = 0, checks = 0, passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [VW-1:0] actual(input int sig);
    case (sig)
      S_RDY:   return VW'(id_ready);
      S_ASEL:  return VW'(fwd_a_sel);
      S_BSEL:  return VW'(fwd_b_sel);
      S_RA:    return VW'(resultA);
      S_RB:    return VW'(resultB);
      S_VA:    return vresultA;
      S_VB:    return vresultB;
`ifdef HAZARD_STATS_EN
      S_STALL: return VW'(stall_cycles);
      S_RAW:   return VW'(raw_stalls);
      S_WAW:   return VW'(waw_stalls);
      S_FWD:   return VW'(fwd_count);
`endif
      default: return 'x;
    endcase
  endfunction

  // Monitor: compare every expectation queued for the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      item_t it;
      logic [VW-1:0] a;
      it = q.pop_front();
      a  = actual(it.sig);
      checks++;
      if (a === it.exp && it.cyc == cyc) passed++;
      else $display("FAIL %s cyc=%0d got=%0h exp=%0h", it.name, it.cyc, a, it.exp);
    end
  end

  task automatic cb();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int sig, input logic [VW-1:0] v, input string nm);
    item_t it;
    it.cyc = cyc; it.sig = sig; it.exp = v; it.name = nm;
    q.push_back(it);
  endtask

  task automatic instr(input logic v, input logic [AW-1:0] rs1, input logic u1,
                       input logic [AW-1:0] rs2, input logic u2,
                       input logic [AW-1:0] rd, input logic we, input logic [CW-1:0] lat);
    id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_we = we; id_lat = lat;
  endtask

  task automatic idle();
    instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 4'd1);
  endtask

  task automatic buses(input logic wm, input logic [AW-1:0] rm, input logic [VW-1:0] dm,
                       input logic ww, input logic [AW-1:0] rw, input logic [VW-1:0] dw);
    write_enable_mem = wm; rd_mem = rm; result_mem = dm;
    write_enable_wb = ww; rd_wb = rw; result_wb = dw;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d exp=finish", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1;
    instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 4'd2);
    buses(1'b1, 5'd0, PAT_M, 1'b1, 5'd0, PAT_W);

    // Reset held two cycles with a valid instruction presented.
    for (int i = 0; i < 2; i++) begin
      cb();
      chk(S_RDY, 0, "rst_ready"); chk(S_ASEL, 0, "rst_asel"); chk(S_BSEL, 0, "rst_bsel");
      chk(S_RA, 0, "rst_ra"); chk(S_RB, 0, "rst_rb"); chk(S_VA, 0, "rst_va"); chk(S_VB, 0, "rst_vb");
    end

    // Load-use: producer rd=3 lat=2, consumer stalls one cycle.
    cb(); rst = 0; buses(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    chk(S_RDY, 1, "post_rst_ready");
    cb(); instr(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 4'd1); chk(S_RDY, 0, "loaduse_stall");
    cb(); chk(S_RDY, 1, "loaduse_go");
    cb(); idle(); buses(1'b1, 5'd3, 256'h1234567890ABCDEF, 1'b0, 5'd0, '0);
    chk(S_ASEL, 1, "loaduse_asel"); chk(S_RA, 32'h90ABCDEF, "loaduse_ra");
    chk(S_VA, 256'h1234567890ABCDEF, "loaduse_va"); chk(S_BSEL, 0, "loaduse_bsel");

    // MEM over WB priority on operand B; operand A reads reg 0.
    cb(); instr(1'b1, 5'd0, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 4'd1); buses(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    chk(S_RDY, 1, "prio_issue");
    cb(); idle(); buses(1'b1, 5'd4, PAT_M, 1'b1, 5'd4, PAT_W);
    chk(S_BSEL, 1, "prio_bsel"); chk(S_VB, PAT_M, "prio_vb"); chk(S_RB, PAT_M[SW-1:0], "prio_rb");
    chk(S_ASEL, 0, "prio_asel");
    cb(); instr(1'b1, 5'd0, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 4'd1);
    chk(S_RDY, 1, "prio_issue2"); chk(S_BSEL, 0, "bubble_bsel");
    cb(); idle(); buses(1'b1, 5'd0, PAT_M, 1'b1, 5'd4, PAT_W);
    chk(S_ASEL, 0, "reg0_asel"); chk(S_RA, 0, "reg0_ra");
    chk(S_BSEL, 2, "wb_bsel"); chk(S_VB, PAT_W, "wb_vb");

    // WAW: rd=9 lat=6, one idle cycle, then rd=9 lat=1 waits while cnt is 5..2.
    cb(); instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 4'd6); buses(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    chk(S_RDY, 1, "waw_first");
    cb(); idle(); chk(S_RDY, 1, "waw_idle");
    for (int i = 0; i < 4; i++) begin
      cb(); instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 4'd1); chk(S_RDY, 0, "waw_stall");
    end
    cb(); chk(S_RDY, 1, "waw_go");

    // Reset mid-stall discards cnt[5]=7.
    cb(); instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 4'd7); chk(S_RDY, 1, "mid_prod");
    cb(); instr(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 4'd1); chk(S_RDY, 0, "mid_stall0");
    cb(); chk(S_RDY, 0, "mid_stall1");
    cb(); rst = 1; chk(S_RDY, 0, "mid_rst");
    cb(); rst = 0; chk(S_RDY, 1, "mid_post_rst");
`ifdef HAZARD_STATS_EN
    chk(S_STALL, 0, "stat_stall0"); chk(S_RAW, 0, "stat_raw0");
    chk(S_WAW, 0, "stat_waw0"); chk(S_FWD, 0, "stat_fwd0");
`endif

    // Vector latency: rd=17 lat=5, consumer on rs2 stalls exactly 4 cycles.
    cb(); instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd17, 1'b1, 4'd5); chk(S_RDY, 1, "vec_prod");
    for (int i = 0; i < 4; i++) begin
      cb(); instr(1'b1, 5'd0, 1'b0, 5'd17, 1'b1, 5'd0, 1'b0, 4'd1); chk(S_RDY, 0, "vec_stall");
    end
    cb(); chk(S_RDY, 1, "vec_go");
    cb(); idle(); buses(1'b1, 5'd17, PAT_M, 1'b0, 5'd0, '0);
    chk(S_BSEL, 1, "vec_bsel"); chk(S_VB, PAT_M, "vec_vb");
`ifdef HAZARD_STATS_EN
    chk(S_STALL, 4, "stat_stall4"); chk(S_RAW, 4, "stat_raw4"); chk(S_WAW, 0, "stat_waw_vec");
`endif
    cb(); buses(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
`ifdef HAZARD_STATS_EN
    chk(S_FWD, 1, "stat_fwd1");
`endif

    // Latency clamping: 0 acts as 1, 15 acts as MAX_LAT=8.
    cb(); instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 4'd0); chk(S_RDY, 1, "lat0_prod");
    cb(); instr(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 4'd1); chk(S_RDY, 1, "lat0_noblock");
    cb(); instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 4'd15); chk(S_RDY, 1, "lat15_prod");
    for (int i = 0; i < 7; i++) begin
      cb(); instr(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 4'd1); chk(S_RDY, 0, "lat15_stall");
    end
    cb(); chk(S_RDY, 1, "lat15_go");

    cb(); idle();
    cb(); cb();
    if (q.size() != 0) begin
      checks++;
      $display("FAIL queue_drain got=%0d exp=0", q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
